// File: rtl/tcp_tx_ctrl_pkg.sv
// tcp_tx_ctrl_pkg: shared types and default widths for the TCP TX control block
package tcp_tx_ctrl_pkg;
  localparam int TCP_FLOWID_W = 6;
  localparam int TCP_PTR_W = 32;
  localparam int TCP_MSS = 1460;
  typedef enum logic [2:0] {IDLE, READ_STATE, WAIT_RESP, CALCULATE, WRITEBACK, PKT_OUT} state_t;
  typedef struct packed {
    logic [TCP_PTR_W-1:0] una;
    logic [TCP_PTR_W-1:0] nxt;
    logic [15:0] win;
  } tx_state_t;
  typedef struct packed {
    logic [TCP_FLOWID_W-1:0] flowid;
    logic [TCP_PTR_W-1:0] seq;
    logic [TCP_PTR_W-1:0] ack;
    logic [15:0] payload_len;
    logic [TCP_PTR_W-1:0] payload_addr;
  } desc_t;
endpackage

// File: rtl/tcp_tx_ctrl_if.sv
// tcp_tx_ctrl_if: scheduler, state-read, writeback and header handshakes of tcp_tx_ctrl
interface tcp_tx_ctrl_if import tcp_tx_ctrl_pkg::*; #(
  parameter int FLOWID_W = TCP_FLOWID_W,
  parameter int PTR_W = TCP_PTR_W
);
  logic sched_tx_req_val;
  logic [FLOWID_W-1:0] sched_tx_req_flowid;
  logic tx_sched_req_rdy;
  logic [FLOWID_W-1:0] state_rd_req_flowid;
  logic curr_tx_state_rd_req_val;
  logic curr_tx_state_rd_req_rdy;
  logic curr_tx_state_rd_resp_val;
  logic curr_tx_state_rd_resp_rdy;
  logic [PTR_W-1:0] curr_tx_state_rd_resp_una;
  logic [PTR_W-1:0] curr_tx_state_rd_resp_nxt;
  logic [15:0] curr_tx_state_rd_resp_win;
  logic tx_tail_ptr_rd_req_val;
  logic tx_tail_ptr_rd_req_rdy;
  logic tx_tail_ptr_rd_resp_val;
  logic tx_tail_ptr_rd_resp_rdy;
  logic [PTR_W-1:0] tx_tail_ptr_rd_resp_data;
  logic curr_rx_state_rd_req_val;
  logic curr_rx_state_rd_req_rdy;
  logic curr_rx_state_rd_resp_val;
  logic curr_rx_state_rd_resp_rdy;
  logic [PTR_W-1:0] curr_rx_state_rd_resp_ack;
  logic next_tx_state_wr_req_val;
  logic next_tx_state_wr_req_rdy;
  logic [FLOWID_W-1:0] next_tx_state_wr_req_flowid;
  logic [PTR_W-1:0] next_tx_state_wr_req_nxt;
  logic tx_dst_hdr_val;
  logic dst_tx_hdr_rdy;
  logic [FLOWID_W-1:0] tx_dst_hdr_flowid;
  logic [PTR_W-1:0] tx_dst_hdr_seq;
  logic [PTR_W-1:0] tx_dst_hdr_ack;
  logic [15:0] tx_dst_hdr_payload_len;
  logic [PTR_W-1:0] tx_dst_hdr_payload_addr;
  modport master (
    input sched_tx_req_val, sched_tx_req_flowid,
    input curr_tx_state_rd_req_rdy, curr_tx_state_rd_resp_val,
    input curr_tx_state_rd_resp_una, curr_tx_state_rd_resp_nxt, curr_tx_state_rd_resp_win,
    input tx_tail_ptr_rd_req_rdy, tx_tail_ptr_rd_resp_val, tx_tail_ptr_rd_resp_data,
    input curr_rx_state_rd_req_rdy, curr_rx_state_rd_resp_val, curr_rx_state_rd_resp_ack,
    input next_tx_state_wr_req_rdy, dst_tx_hdr_rdy,
    output tx_sched_req_rdy, state_rd_req_flowid,
    output curr_tx_state_rd_req_val, curr_tx_state_rd_resp_rdy,
    output tx_tail_ptr_rd_req_val, tx_tail_ptr_rd_resp_rdy,
    output curr_rx_state_rd_req_val, curr_rx_state_rd_resp_rdy,
    output next_tx_state_wr_req_val, next_tx_state_wr_req_flowid, next_tx_state_wr_req_nxt,
    output tx_dst_hdr_val, tx_dst_hdr_flowid, tx_dst_hdr_seq, tx_dst_hdr_ack,
    output tx_dst_hdr_payload_len, tx_dst_hdr_payload_addr
  );
  modport slave (
    output sched_tx_req_val, sched_tx_req_flowid,
    output curr_tx_state_rd_req_rdy, curr_tx_state_rd_resp_val,
    output curr_tx_state_rd_resp_una, curr_tx_state_rd_resp_nxt, curr_tx_state_rd_resp_win,
    output tx_tail_ptr_rd_req_rdy, tx_tail_ptr_rd_resp_val, tx_tail_ptr_rd_resp_data,
    output curr_rx_state_rd_req_rdy, curr_rx_state_rd_resp_val, curr_rx_state_rd_resp_ack,
    output next_tx_state_wr_req_rdy, dst_tx_hdr_rdy,
    input tx_sched_req_rdy, state_rd_req_flowid,
    input curr_tx_state_rd_req_val, curr_tx_state_rd_resp_rdy,
    input tx_tail_ptr_rd_req_val, tx_tail_ptr_rd_resp_rdy,
    input curr_rx_state_rd_req_val, curr_rx_state_rd_resp_rdy,
    input next_tx_state_wr_req_val, next_tx_state_wr_req_flowid, next_tx_state_wr_req_nxt,
    input tx_dst_hdr_val, tx_dst_hdr_flowid, tx_dst_hdr_seq, tx_dst_hdr_ack,
    input tx_dst_hdr_payload_len, tx_dst_hdr_payload_addr
  );
endinterface

// File: rtl/tcp_tx_len_calc.sv
// tcp_tx_len_calc: payload length = min(unsent, usable window, MSS), modulo-2^PTR_W arithmetic
module tcp_tx_len_calc import tcp_tx_ctrl_pkg::*; #(
  parameter int PTR_W = TCP_PTR_W,
  parameter int MSS = TCP_MSS
) (
  input  logic [PTR_W-1:0] una,
  input  logic [PTR_W-1:0] nxt,
  input  logic [PTR_W-1:0] tail,
  input  logic [15:0]      win,
  output logic [15:0]      len
);
  logic [PTR_W-1:0] unsent, wsum, wavail, m;
  // a window sum larger than win can only mean nxt already ran past the window
  always_comb begin
    unsent = tail - nxt;
    wsum = una + PTR_W'(win) - nxt;
    wavail = wsum > PTR_W'(win) ? '0 : wsum;
    m = unsent < wavail ? unsent : wavail;
    m = m < PTR_W'(MSS) ? m : PTR_W'(MSS);
    len = 16'(m);
  end
endmodule

// File: rtl/tcp_tx_ctrl.sv
// tcp_tx_ctrl: per-flow TX control; reads flow state, sizes one segment,
// writes back the send pointer and emits one header descriptor
module tcp_tx_ctrl import tcp_tx_ctrl_pkg::*; #(
  parameter int FLOWID_W = TCP_FLOWID_W,
  parameter int PTR_W = TCP_PTR_W,
  parameter int MSS = TCP_MSS
) (
  input logic clk,
  input logic rst,
  tcp_tx_ctrl_if.master bus
);
  state_t state, state_nxt;
  logic [FLOWID_W-1:0] flowid;
  tx_state_t txs;
  logic [PTR_W-1:0] tail, ack, new_nxt;
  desc_t desc;
  logic [15:0] len;
  logic req_go, resp_go;
  assign req_go = bus.curr_tx_state_rd_req_rdy & bus.tx_tail_ptr_rd_req_rdy & bus.curr_rx_state_rd_req_rdy;
  assign resp_go = bus.curr_tx_state_rd_resp_val & bus.tx_tail_ptr_rd_resp_val & bus.curr_rx_state_rd_resp_val;
  tcp_tx_len_calc #(.PTR_W(PTR_W), .MSS(MSS)) u_len_calc (
    .una(txs.una), .nxt(txs.nxt), .tail(tail), .win(txs.win), .len(len)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = bus.sched_tx_req_val ? READ_STATE : IDLE;
      READ_STATE: state_nxt = req_go ? WAIT_RESP : READ_STATE;
      WAIT_RESP:  state_nxt = resp_go ? CALCULATE : WAIT_RESP;
      CALCULATE:  state_nxt = len == '0 ? IDLE : WRITEBACK;
      WRITEBACK:  state_nxt = bus.next_tx_state_wr_req_rdy ? PKT_OUT : WRITEBACK;
      PKT_OUT:    state_nxt = bus.dst_tx_hdr_rdy ? IDLE : PKT_OUT;
      default:    state_nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.tx_sched_req_rdy = state == IDLE;
    bus.curr_tx_state_rd_req_val = state == READ_STATE;
    bus.tx_tail_ptr_rd_req_val = state == READ_STATE;
    bus.curr_rx_state_rd_req_val = state == READ_STATE;
    bus.curr_tx_state_rd_resp_rdy = state == WAIT_RESP && resp_go;
    bus.tx_tail_ptr_rd_resp_rdy = state == WAIT_RESP && resp_go;
    bus.curr_rx_state_rd_resp_rdy = state == WAIT_RESP && resp_go;
    bus.next_tx_state_wr_req_val = state == WRITEBACK;
    bus.tx_dst_hdr_val = state == PKT_OUT;
  end
  always_ff @(posedge clk)
    if (rst) begin
      flowid <= '0;
      txs <= '0;
      tail <= '0;
      ack <= '0;
      desc <= '0;
      new_nxt <= '0;
    end else begin
      if (state == IDLE && bus.sched_tx_req_val) flowid <= bus.sched_tx_req_flowid;
      if (state == WAIT_RESP && resp_go) begin
        txs <= '{una: bus.curr_tx_state_rd_resp_una, nxt: bus.curr_tx_state_rd_resp_nxt,
                 win: bus.curr_tx_state_rd_resp_win};
        tail <= bus.tx_tail_ptr_rd_resp_data;
        ack <= bus.curr_rx_state_rd_resp_ack;
      end
      if (state == CALCULATE) begin
        desc <= '{flowid: flowid, seq: txs.nxt, ack: ack, payload_len: len, payload_addr: txs.nxt};
        new_nxt <= txs.nxt + PTR_W'(len);
      end
    end
  assign bus.state_rd_req_flowid = flowid;
  assign bus.next_tx_state_wr_req_flowid = flowid;
  assign bus.next_tx_state_wr_req_nxt = new_nxt;
  assign bus.tx_dst_hdr_flowid = desc.flowid;
  assign bus.tx_dst_hdr_seq = desc.seq;
  assign bus.tx_dst_hdr_ack = desc.ack;
  assign bus.tx_dst_hdr_payload_len = desc.payload_len;
  assign bus.tx_dst_hdr_payload_addr = desc.payload_addr;
endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// tb_tcp_tx_ctrl: table-driven length-calc vectors plus directed flow sequences for tcp_tx_ctrl
module tb_tcp_tx_ctrl;
  logic clk, rst;
  int checks, errors;
  tcp_tx_ctrl_if bus();
  tcp_tx_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] lc_una, lc_nxt, lc_tail;
  logic [15:0] lc_win, lc_len;
  tcp_tx_len_calc u_lc (.una(lc_una), .nxt(lc_nxt), .tail(lc_tail), .win(lc_win), .len(lc_len));
  typedef struct {
    logic [31:0] una;
    logic [31:0] nxt;
    logic [31:0] tail;
    logic [15:0] win;
    logic [15:0] len;
  } lc_vec_t;
  lc_vec_t vecs[11];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_flow(input logic [5:0] fid, input logic [31:0] una, input logic [31:0] nxt,
                          input logic [31:0] tail, input logic [31:0] ack, input logic [15:0] win,
                          input int rx_hold, input int tail_late, input int hold, input bit abort,
                          input logic [15:0] exp_len, input logic [31:0] exp_nxt);
    chk("idle_rdy", 64'(bus.tx_sched_req_rdy), 64'd1);
    bus.sched_tx_req_val = 1'b1;
    bus.sched_tx_req_flowid = fid;
    @(negedge clk);
    bus.sched_tx_req_val = 1'b0;
    bus.sched_tx_req_flowid = 6'd0;
    chk("busy_rdy", 64'(bus.tx_sched_req_rdy), 64'd0);
    chk("rd_flowid", 64'(bus.state_rd_req_flowid), 64'(fid));
    for (int i = 0; i < rx_hold; i++) begin
      bus.curr_tx_state_rd_req_rdy = 1'b1;
      bus.tx_tail_ptr_rd_req_rdy = 1'b1;
      bus.curr_rx_state_rd_req_rdy = 1'b0;
      chk("rd_req_hold", 64'({bus.curr_tx_state_rd_req_val, bus.tx_tail_ptr_rd_req_val, bus.curr_rx_state_rd_req_val}), 64'd7);
      @(negedge clk);
    end
    chk("rd_req_val", 64'({bus.curr_tx_state_rd_req_val, bus.tx_tail_ptr_rd_req_val, bus.curr_rx_state_rd_req_val}), 64'd7);
    bus.curr_tx_state_rd_req_rdy = 1'b1;
    bus.tx_tail_ptr_rd_req_rdy = 1'b1;
    bus.curr_rx_state_rd_req_rdy = 1'b1;
    @(negedge clk);
    bus.curr_tx_state_rd_req_rdy = 1'b0;
    bus.tx_tail_ptr_rd_req_rdy = 1'b0;
    bus.curr_rx_state_rd_req_rdy = 1'b0;
    chk("rd_req_drop", 64'({bus.curr_tx_state_rd_req_val, bus.tx_tail_ptr_rd_req_val, bus.curr_rx_state_rd_req_val}), 64'd0);
    bus.curr_tx_state_rd_resp_una = una;
    bus.curr_tx_state_rd_resp_nxt = nxt;
    bus.curr_tx_state_rd_resp_win = win;
    bus.tx_tail_ptr_rd_resp_data = tail;
    bus.curr_rx_state_rd_resp_ack = ack;
    bus.curr_tx_state_rd_resp_val = 1'b1;
    bus.curr_rx_state_rd_resp_val = 1'b1;
    bus.tx_tail_ptr_rd_resp_val = 1'b0;
    for (int i = 0; i < tail_late; i++) begin
      #1;
      chk("resp_rdy_hold", 64'({bus.curr_tx_state_rd_resp_rdy, bus.tx_tail_ptr_rd_resp_rdy, bus.curr_rx_state_rd_resp_rdy}), 64'd0);
      @(negedge clk);
    end
    bus.tx_tail_ptr_rd_resp_val = 1'b1;
    #1;
    chk("resp_rdy", 64'({bus.curr_tx_state_rd_resp_rdy, bus.tx_tail_ptr_rd_resp_rdy, bus.curr_rx_state_rd_resp_rdy}), 64'd7);
    @(negedge clk);
    bus.curr_tx_state_rd_resp_val = 1'b0;
    bus.curr_rx_state_rd_resp_val = 1'b0;
    bus.tx_tail_ptr_rd_resp_val = 1'b0;
    bus.curr_tx_state_rd_resp_una = ~una;
    bus.curr_tx_state_rd_resp_nxt = ~nxt;
    bus.curr_tx_state_rd_resp_win = ~win;
    bus.tx_tail_ptr_rd_resp_data = ~tail;
    bus.curr_rx_state_rd_resp_ack = ~ack;
    chk("calc_no_wb", 64'(bus.next_tx_state_wr_req_val), 64'd0);
    chk("calc_busy", 64'(bus.tx_sched_req_rdy), 64'd0);
    @(negedge clk);
    if (exp_len == 16'd0) begin
      chk("zero_idle", 64'(bus.tx_sched_req_rdy), 64'd1);
      chk("zero_no_wb", 64'(bus.next_tx_state_wr_req_val), 64'd0);
      chk("zero_no_hdr", 64'(bus.tx_dst_hdr_val), 64'd0);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      chk("wb_hold", 64'(bus.next_tx_state_wr_req_val), 64'd1);
      @(negedge clk);
    end
    chk("wb_val", 64'(bus.next_tx_state_wr_req_val), 64'd1);
    chk("wb_flowid", 64'(bus.next_tx_state_wr_req_flowid), 64'(fid));
    chk("wb_nxt", 64'(bus.next_tx_state_wr_req_nxt), 64'(exp_nxt));
    chk("wb_no_hdr", 64'(bus.tx_dst_hdr_val), 64'd0);
    bus.next_tx_state_wr_req_rdy = 1'b1;
    @(negedge clk);
    bus.next_tx_state_wr_req_rdy = 1'b0;
    chk("hdr_val", 64'(bus.tx_dst_hdr_val), 64'd1);
    chk("hdr_wb_off", 64'(bus.next_tx_state_wr_req_val), 64'd0);
    chk("hdr_flowid", 64'(bus.tx_dst_hdr_flowid), 64'(fid));
    chk("hdr_seq", 64'(bus.tx_dst_hdr_seq), 64'(nxt));
    chk("hdr_ack", 64'(bus.tx_dst_hdr_ack), 64'(ack));
    chk("hdr_len", 64'(bus.tx_dst_hdr_payload_len), 64'(exp_len));
    chk("hdr_addr", 64'(bus.tx_dst_hdr_payload_addr), 64'(nxt));
    if (abort) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_hdr_off", 64'(bus.tx_dst_hdr_val), 64'd0);
      chk("rst_idle_rdy", 64'(bus.tx_sched_req_rdy), 64'd1);
      chk("rst_no_wb", 64'(bus.next_tx_state_wr_req_val), 64'd0);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hdr_hold_val", 64'(bus.tx_dst_hdr_val), 64'd1);
      chk("hdr_hold_len", 64'(bus.tx_dst_hdr_payload_len), 64'(exp_len));
    end
    bus.dst_tx_hdr_rdy = 1'b1;
    @(negedge clk);
    bus.dst_tx_hdr_rdy = 1'b0;
    chk("hdr_done", 64'(bus.tx_dst_hdr_val), 64'd0);
    chk("back_idle", 64'(bus.tx_sched_req_rdy), 64'd1);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.sched_tx_req_val = 1'b0;
    bus.sched_tx_req_flowid = 6'd0;
    bus.curr_tx_state_rd_req_rdy = 1'b0;
    bus.curr_tx_state_rd_resp_val = 1'b0;
    bus.curr_tx_state_rd_resp_una = 32'd0;
    bus.curr_tx_state_rd_resp_nxt = 32'd0;
    bus.curr_tx_state_rd_resp_win = 16'd0;
    bus.tx_tail_ptr_rd_req_rdy = 1'b0;
    bus.tx_tail_ptr_rd_resp_val = 1'b0;
    bus.tx_tail_ptr_rd_resp_data = 32'd0;
    bus.curr_rx_state_rd_req_rdy = 1'b0;
    bus.curr_rx_state_rd_resp_val = 1'b0;
    bus.curr_rx_state_rd_resp_ack = 32'd0;
    bus.next_tx_state_wr_req_rdy = 1'b0;
    bus.dst_tx_hdr_rdy = 1'b0;
    vecs = '{
      '{32'd100, 32'd100, 32'd3100, 16'd4000, 16'd1460},
      '{32'd100, 32'd600, 32'd5000, 16'd700, 16'd200},
      '{32'h200, 32'h200, 32'h200, 16'd1000, 16'd0},
      '{32'hFFFFFF00, 32'hFFFFFF00, 32'h100, 16'hFFFF, 16'd512},
      '{32'd100, 32'd900, 32'd5000, 16'd700, 16'd0},
      '{32'd1000, 32'd1700, 32'd5000, 16'd700, 16'd0},
      '{32'd1000, 32'd1699, 32'd5000, 16'd700, 16'd1},
      '{32'd0, 32'd0, 32'd1460, 16'd2000, 16'd1460},
      '{32'd0, 32'd0, 32'd1461, 16'd2000, 16'd1460},
      '{32'd0, 32'd0, 32'd1459, 16'd2000, 16'd1459},
      '{32'd500, 32'd500, 32'd400, 16'd300, 16'd300}
    };
    for (int i = 0; i < 11; i++) begin
      lc_una = vecs[i].una;
      lc_nxt = vecs[i].nxt;
      lc_tail = vecs[i].tail;
      lc_win = vecs[i].win;
      #1;
      chk($sformatf("len_calc[%0d]", i), 64'(lc_len), 64'(vecs[i].len));
    end
    repeat (2) @(negedge clk);
    chk("rst_sched_rdy", 64'(bus.tx_sched_req_rdy), 64'd1);
    chk("rst_rd_req", 64'({bus.curr_tx_state_rd_req_val, bus.tx_tail_ptr_rd_req_val, bus.curr_rx_state_rd_req_val}), 64'd0);
    chk("rst_wb_val", 64'(bus.next_tx_state_wr_req_val), 64'd0);
    chk("rst_hdr_val", 64'(bus.tx_dst_hdr_val), 64'd0);
    chk("rst_hdr_seq", 64'(bus.tx_dst_hdr_seq), 64'd0);
    chk("rst_wb_nxt", 64'(bus.next_tx_state_wr_req_nxt), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_flow(6'd5, 32'd100, 32'd100, 32'd3100, 32'h12345678, 16'd4000, 0, 0, 0, 1'b0, 16'd1460, 32'd1560);
    run_flow(6'd9, 32'd100, 32'd600, 32'd5000, 32'hA5A50001, 16'd700, 0, 0, 1, 1'b0, 16'd200, 32'd800);
    run_flow(6'd12, 32'h200, 32'h200, 32'h200, 32'd7, 16'd1000, 0, 0, 0, 1'b0, 16'd0, 32'h200);
    run_flow(6'd63, 32'hFFFFFF00, 32'hFFFFFF00, 32'h100, 32'hDEADBEEF, 16'hFFFF, 0, 0, 0, 1'b0, 16'd512, 32'h100);
    run_flow(6'd1, 32'd100, 32'd600, 32'd5000, 32'h55, 16'd700, 3, 2, 0, 1'b0, 16'd200, 32'd800);
    run_flow(6'd33, 32'd100, 32'd100, 32'd3100, 32'd1, 16'd4000, 0, 0, 0, 1'b1, 16'd1460, 32'd1560);
    run_flow(6'd2, 32'd0, 32'd0, 32'd1461, 32'd9, 16'd2000, 0, 0, 0, 1'b0, 16'd1460, 32'd1460);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
